genius_jogo_param: RTL and testbench

Parametrised successor of the 4-button memory-game controller: N_CHAVES buttons, sequence depth MAX_RODADAS, two difficulty levels and per-play timeout. Sequence is held in an internal RAM loaded through a write port while idle. Each round r replays positions 0..r and grows by one until the level limit is cleared, a wrong play, or a timeout. Sits between the board switch/LED I/O and the 7-seg debug decoders.

---
 rtl/genius_jogo_param.sv | 201 ++++++++++++++++++++
 tb/tb_genius_jogo_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/genius_jogo_param.sv
// Parametrised memory-game controller: N_CHAVES buttons, MAX_RODADAS-deep
// sequence RAM loaded while idle, two difficulty levels and a per-play timeout.
// Optional sequence display state (MOSTRA) is built when SHOW_SEQ_EN is defined.
module genius_jogo_param #(
    parameter int N_CHAVES       = 4,
    parameter int MAX_RODADAS    = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int SHOW_CICLOS    = 500
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                sel_nivel,
    input  logic [N_CHAVES-1:0] chaves,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [N_CHAVES-1:0] load_data,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [N_CHAVES-1:0] leds,
    output logic [ADDR_W-1:0]   db_rodada,
    output logic [ADDR_W-1:0]   db_endereco,
    output logic [3:0]          db_estado
);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        PREPARA     = 4'd1,
        ESPERA      = 4'd2,
        COMPARA     = 4'd3,
        PROX_JOGADA = 4'd4,
        PROX_RODADA = 4'd5,
        ACERTOU     = 4'd6,
        ERROU       = 4'd7,
        TIMEOUT     = 4'd8,
        MOSTRA      = 4'd9
    } state_t;

    state_t              state;
    logic [N_CHAVES-1:0] mem [MAX_RODADAS];
    logic [N_CHAVES-1:0] chaves_r;
    logic [N_CHAVES-1:0] jogada_r;
    logic [ADDR_W-1:0]   rodada;
    logic [ADDR_W-1:0]   endereco;
    logic [ADDR_W-1:0]   limite;
    logic [TW-1:0]       timer;
    logic                jogada;
    logic                hit;
`ifdef SHOW_SEQ_EN
    localparam int SW = $clog2(SHOW_CICLOS + 1);
    logic [SW-1:0]       show_cnt;
    logic [ADDR_W-1:0]   show_idx;
    logic                show_off;
`endif

    // rising edge of "any key pressed": a held key counts as one play
    assign jogada = (|chaves) & ~(|chaves_r);

    // valid play: exactly one key and it matches the stored element
    always_comb begin
        hit = (jogada_r != '0) &&
              ((jogada_r & (jogada_r - N_CHAVES'(1))) == '0) &&
              (jogada_r == mem[endereco]);
    end

    assign db_rodada   = rodada;
    assign db_endereco = endereco;
    assign db_estado   = state;

    // sequence RAM: written only while idle, deliberately not reset
    always_ff @(posedge clock) begin
        if (load_en && state == IDLE) mem[load_addr] <= load_data;
    end

    // game FSM with registered flags and counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            chaves_r <= '0;
            jogada_r <= '0;
            rodada   <= '0;
            endereco <= '0;
            limite   <= '0;
            timer    <= '0;
            leds     <= '0;
            pronto   <= 1'b0;
            acertou  <= 1'b0;
            errou    <= 1'b0;
            timeout  <= 1'b0;
`ifdef SHOW_SEQ_EN
            show_cnt <= '0;
            show_idx <= '0;
            show_off <= 1'b0;
`endif
        end else begin
            chaves_r <= chaves;
            case (state)
                IDLE: if (iniciar) state <= PREPARA;
                PREPARA: begin
                    rodada   <= '0;
                    endereco <= '0;
                    timer    <= '0;
                    limite   <= sel_nivel ? ADDR_W'(MAX_RODADAS - 1) : ADDR_W'(MAX_RODADAS / 2 - 1);
`ifdef SHOW_SEQ_EN
                    state    <= MOSTRA;
                    show_cnt <= '0;
                    show_idx <= '0;
                    show_off <= 1'b0;
                    leds     <= mem[0];
`else
                    state    <= ESPERA;
`endif
                end
                ESPERA: begin
                    // a play landing on the last allowed cycle still counts
                    if (jogada) begin
                        jogada_r <= chaves;
                        leds     <= chaves;
                        timer    <= '0;
                        state    <= COMPARA;
                    end else if (timer == TW'(TIMEOUT_CICLOS - 1)) begin
                        state   <= TIMEOUT;
                        pronto  <= 1'b1;
                        errou   <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                COMPARA: begin
                    if (!hit) begin
                        state  <= ERROU;
                        pronto <= 1'b1;
                        errou  <= 1'b1;
                    end else if (endereco != rodada) begin
                        state <= PROX_JOGADA;
                    end else if (rodada == limite) begin
                        state   <= ACERTOU;
                        pronto  <= 1'b1;
                        acertou <= 1'b1;
                    end else begin
                        state <= PROX_RODADA;
                    end
                end
                PROX_JOGADA: begin
                    endereco <= endereco + ADDR_W'(1);
                    state    <= ESPERA;
                end
                PROX_RODADA: begin
                    rodada   <= rodada + ADDR_W'(1);
                    endereco <= '0;
`ifdef SHOW_SEQ_EN
                    state    <= MOSTRA;
                    show_cnt <= '0;
                    show_idx <= '0;
                    show_off <= 1'b0;
                    leds     <= mem[0];
`else
                    state    <= ESPERA;
`endif
                end
                ACERTOU, ERROU, TIMEOUT: begin
                    if (iniciar) begin
                        state   <= PREPARA;
                        pronto  <= 1'b0;
                        acertou <= 1'b0;
                        errou   <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
`ifdef SHOW_SEQ_EN
                MOSTRA: begin
                    // each element: SHOW_CICLOS on, SHOW_CICLOS dark; keys ignored
                    if (show_cnt == SW'(SHOW_CICLOS - 1)) begin
                        show_cnt <= '0;
                        if (!show_off) begin
                            show_off <= 1'b1;
                            leds     <= '0;
                        end else if (show_idx == rodada) begin
                            endereco <= '0;
                            timer    <= '0;
                            state    <= ESPERA;
                        end else begin
                            show_idx <= show_idx + ADDR_W'(1);
                            show_off <= 1'b0;
                            leds     <= mem[show_idx + ADDR_W'(1)];
                        end
                    end else begin
                        show_cnt <= show_cnt + SW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_genius_jogo_param.sv
// Bench for genius_jogo_param: scoreboard of expected game endings plus
// inline checks of reset, play detection, timeout length and RAM retention.
module tb_genius_jogo_param;
    localparam int N  = 4;
    localparam int R  = 16;
    localparam int AW = 4;
    localparam int TO = 20;

    logic          clock = 1'b0;
    logic          reset, iniciar, sel_nivel, load_en;
    logic [N-1:0]  chaves, load_data, leds;
    logic [AW-1:0] load_addr, db_rodada, db_endereco;
    logic          pronto, acertou, errou, timeout;
    logic [3:0]    db_estado;

    typedef struct {
        logic       ac, er, to;
        logic [3:0] rod, endr, est;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] model_mem [R];
    int           total = 0;
    int           bad = 0;
    int           nplay = 0;

    genius_jogo_param #(.N_CHAVES(N), .MAX_RODADAS(R), .ADDR_W(AW),
                        .TIMEOUT_CICLOS(TO), .SHOW_CICLOS(3)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .sel_nivel(sel_nivel),
        .chaves(chaves), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .leds(leds), .db_rodada(db_rodada), .db_endereco(db_endereco), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic wait_espera();
        int n = 0;
        while (db_estado != 4'd2 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (db_estado != 4'd2) chk("wait_espera", db_estado, 2);
    endtask

    task automatic press(input logic [N-1:0] k, input int hold);
        wait_espera();
        chaves = k;
        nplay++;
        @(negedge clock);
        chk("leds_play", leds, k);
        repeat (hold - 1) @(negedge clock);
        chaves = '0;
        @(negedge clock);
    endtask

    task automatic play_round(input int r);
        for (int p = 0; p <= r; p++) press(model_mem[p], 1);
    endtask

    task automatic start(input logic sel);
        sel_nivel = sel;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        chk("prepara", db_estado, 1);
        chk("flags_clr", {pronto, acertou, errou, timeout}, 0);
    endtask

    task automatic push_exp(input logic ac, input logic er, input logic to,
                            input logic [3:0] rod, input logic [3:0] endr, input logic [3:0] est);
        exp_t e;
        e.ac = ac; e.er = er; e.to = to; e.rod = rod; e.endr = endr; e.est = est;
        exp_q.push_back(e);
    endtask

    task automatic finish_game();
        exp_t e;
        int n = 0;
        while (!pronto && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("pronto", pronto, 1);
        chk("sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("acertou", acertou, e.ac);
            chk("errou", errou, e.er);
            chk("timeout", timeout, e.to);
            chk("rodada", db_rodada, e.rod);
            chk("endereco", db_endereco, e.endr);
            chk("estado", db_estado, e.est);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=done");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; iniciar = 1'b0; sel_nivel = 1'b0; chaves = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(negedge clock);
        chk("rst_out", {pronto, acertou, errou, timeout, leds, db_rodada, db_endereco, db_estado}, 0);
        reset = 1'b1;
        @(negedge clock);

        // sequence 0001,0010,0100,1000 repeating
        for (int i = 0; i < R; i++) begin
            model_mem[i] = N'(1) << (i % 4);
            load_en = 1'b1; load_addr = AW'(i); load_data = model_mem[i];
            @(negedge clock);
        end
        load_en = 1'b0;

        // full level, wrong third play in round 4
        push_exp(0, 1, 0, 3, 2, 7);
        start(1);
        for (int r = 0; r < 3; r++) begin
            play_round(r);
            wait_espera();
            chk("rodada_up", db_rodada, r + 1);
        end
        press(4'b0001, 1); press(4'b0010, 1); press(4'b0010, 1);
        finish_game();

        // writes outside IDLE must be dropped
        load_en = 1'b1; load_addr = '0; load_data = 4'b1000;
        @(negedge clock);
        load_en = 1'b0;
        chk("err_hold", db_estado, 7);

        // easy level cleared in 8 rounds / 36 plays
        push_exp(1, 0, 0, 7, 7, 6);
        nplay = 0;
        start(0);
        play_round(0);
        wait_espera();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        chk("ini_ignored", db_estado, 2);
        chk("ini_rodada", db_rodada, 1);
        for (int r = 1; r < 8; r++) begin
            if (r == 7) begin
                for (int p = 0; p < 7; p++) press(model_mem[p], 1);
                chk("no_early_win", acertou, 0);
                press(model_mem[7], 1);
            end else begin
                play_round(r);
            end
        end
        chk("plays", nplay, 36);
        finish_game();

        // timeout: exactly TO cycles in ESPERA
        push_exp(0, 1, 1, 1, 0, 8);
        start(1);
        play_round(0);
        wait_espera();
        n = 0;
        while (db_estado == 4'd2 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("to_cycles", n, TO);
        finish_game();

        // held key counts once, then a two-hot press is wrong
        push_exp(0, 1, 0, 1, 0, 7);
        start(1);
        press(4'b0001, 10);
        press(4'b0011, 1);
        finish_game();

        // async reset mid round 3, restart keeps RAM
        start(1);
        for (int r = 0; r < 3; r++) play_round(r);
        press(model_mem[0], 1);
        wait_espera();
        reset = 1'b0;
        #1;
        chk("rst_mid", {pronto, acertou, errou, timeout, leds, db_rodada, db_endereco, db_estado}, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        push_exp(0, 1, 0, 1, 0, 7);
        start(1);
        wait_espera();
        chk("restart_rod", db_rodada, 0);
        press(model_mem[0], 1);
        wait_espera();
        chk("ram_kept", db_rodada, 1);
        press(4'b0100, 1);
        finish_game();

        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
